// File: rtl/bram_b_arbiter.sv
// Port B arbiter: VGA scan-out has priority, aux master gets a forced slot after
// STARVE_MAX denied cycles. An owner tag routes the 1-cycle BRAM read data back.
module bram_b_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic [DATA_W-1:0] vga_rdata,
   output logic              vga_valid,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_gnt,
   output logic [DATA_W-1:0] aux_rdata,
   output logic              aux_valid,
   output logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] data_b,
   output logic              we_b,
   input  logic [DATA_W-1:0] q_b
);

   typedef enum logic [1:0] {
      TAG_NONE   = 2'd0,
      TAG_VGA    = 2'd1,
      TAG_AUX_RD = 2'd2
   } tag_t;

   localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX);

   logic [7:0]        starve_cnt_r;
   tag_t              tag_r;
   tag_t              tag_next_s;
   logic [ADDR_W-1:0] addr_hold_r;
   logic              force_s;
   logic              aux_gnt_s;
   logic              vga_gnt_s;

   // Single-cycle grant decision; nothing is granted while in reset.
   always_comb begin
      force_s   = 1'b0;
      aux_gnt_s = 1'b0;
      vga_gnt_s = 1'b0;
      if (rst) begin
         force_s   = 1'b0;
         aux_gnt_s = 1'b0;
         vga_gnt_s = 1'b0;
      end else begin
         force_s   = aux_req && (starve_cnt_r == STARVE_LIMIT);
         aux_gnt_s = aux_req && (!vga_req || force_s);
         vga_gnt_s = vga_req && !aux_gnt_s;
      end
   end

   // Port B mux and next owner tag; an idle cycle keeps the previous address.
   always_comb begin
      addr_b     = addr_hold_r;
      we_b       = 1'b0;
      data_b     = '0;
      tag_next_s = TAG_NONE;
      if (rst) begin
         addr_b = '0;
      end else if (vga_gnt_s) begin
         addr_b     = vga_addr;
         tag_next_s = TAG_VGA;
      end else if (aux_gnt_s) begin
         addr_b     = aux_addr;
         we_b       = aux_we;
         data_b     = aux_wdata;
         tag_next_s = aux_we ? TAG_NONE : TAG_AUX_RD;
      end else begin
         addr_b = addr_hold_r;
      end
   end

   // Owner pipeline, held address and starvation counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_r        <= TAG_NONE;
         addr_hold_r  <= '0;
         starve_cnt_r <= 8'd0;
      end else begin
         tag_r       <= tag_next_s;
         addr_hold_r <= addr_b;
         if (!aux_req || aux_gnt_s) begin
            starve_cnt_r <= 8'd0;
         end else if (starve_cnt_r < STARVE_LIMIT) begin
            starve_cnt_r <= starve_cnt_r + 8'd1;
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end
   end

   // A reset arriving mid-read kills the pending valid immediately.
   assign vga_valid = !rst && (tag_r == TAG_VGA);
   assign aux_valid = !rst && (tag_r == TAG_AUX_RD);
   assign vga_rdata = q_b;
   assign aux_rdata = q_b;
   assign vga_gnt   = vga_gnt_s;
   assign aux_gnt   = aux_gnt_s;

endmodule

// File: tb/tb_bram_b_arbiter.sv
// Self-checking bench for bram_b_arbiter with a behavioural 1-cycle BRAM on port B.
module tb_bram_b_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        vga_req;
   logic [15:0] vga_addr;
   logic        vga_gnt;
   logic [15:0] vga_rdata;
   logic        vga_valid;
   logic        aux_req;
   logic        aux_we;
   logic [15:0] aux_addr;
   logic [15:0] aux_wdata;
   logic        aux_gnt;
   logic [15:0] aux_rdata;
   logic        aux_valid;
   logic [15:0] addr_b;
   logic [15:0] data_b;
   logic        we_b;
   logic [15:0] q_b = 16'h0000;

   logic [15:0] mem     [65536];
   logic [15:0] ref_mem [65536];

   typedef struct {
      bit          is_aux;
      logic [15:0] data;
   } exp_t;
   exp_t sb[$];

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] last_addr = 16'h0000;

   bram_b_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(8)) dut (
      .clk(clk), .rst(rst),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
      .vga_rdata(vga_rdata), .vga_valid(vga_valid),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
      .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rdata(aux_rdata),
      .aux_valid(aux_valid),
      .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b)
   );

   always #5 clk = ~clk;

   // Port B memory: registered read, write-first across cycles.
   always @(posedge clk) begin
      if (we_b) mem[addr_b] <= data_b;
      q_b <= mem[addr_b];
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check valids of the previous grant, check grants, queue reads.
   task automatic step(input bit r, input bit vr, input logic [15:0] va,
                       input bit ar, input bit aw, input logic [15:0] aa, input logic [15:0] ad,
                       input bit evg, input bit eag, input string name);
      exp_t        e;
      bit          have;
      logic [15:0] exp_addr;
      rst = r; vga_req = vr; vga_addr = va;
      aux_req = ar; aux_we = aw; aux_addr = aa; aux_wdata = ad;
      #1;
      have = (sb.size() > 0);
      if (have) e = sb.pop_front();
      if (r || !have) begin
         check_val({name, ".vvalid"}, {31'd0, vga_valid}, 32'd0);
         check_val({name, ".avalid"}, {31'd0, aux_valid}, 32'd0);
      end else begin
         check_val({name, ".vvalid"}, {31'd0, vga_valid}, {31'd0, !e.is_aux});
         check_val({name, ".avalid"}, {31'd0, aux_valid}, {31'd0, e.is_aux});
         check_val({name, ".rdata"}, {16'd0, (e.is_aux ? aux_rdata : vga_rdata)}, {16'd0, e.data});
      end
      check_val({name, ".vgnt"}, {31'd0, vga_gnt}, {31'd0, evg});
      check_val({name, ".agnt"}, {31'd0, aux_gnt}, {31'd0, eag});
      check_val({name, ".we_b"}, {31'd0, we_b}, {31'd0, eag && aw});
      exp_addr = r ? 16'h0000 : (evg ? va : (eag ? aa : last_addr));
      check_val({name, ".addr_b"}, {16'd0, addr_b}, {16'd0, exp_addr});
      last_addr = exp_addr;
      if (!r && evg) sb.push_back('{is_aux: 1'b0, data: ref_mem[va]});
      if (!r && eag && !aw) sb.push_back('{is_aux: 1'b1, data: ref_mem[aa]});
      if (!r && eag && aw) ref_mem[aa] = ad;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 16'h0000;
         ref_mem[i] = 16'h0000;
      end
      mem[16'h0040] = 16'hBEEF; ref_mem[16'h0040] = 16'hBEEF;
      mem[16'h0010] = 16'h1111; ref_mem[16'h0010] = 16'h1111;
      mem[16'h0020] = 16'h2222; ref_mem[16'h0020] = 16'h2222;
      mem[16'h0030] = 16'h3333; ref_mem[16'h0030] = 16'h3333;
      mem[16'h0200] = 16'h5555; ref_mem[16'h0200] = 16'h5555;

      // Reset then idle
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "rst");
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "idle");
      check_val("idle.starve", {24'd0, dut.starve_cnt_r}, 32'd0);

      // VGA read alone
      step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "vga_rd");
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "vga_rd_ret");

      // Aux write then read-after-write
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0, 1'b1, "aux_wr");
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0100, 16'h0, 1'b0, 1'b1, "aux_rd");
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "aux_rd_ret");

      // Contention: 8 VGA grants then one forced aux grant, repeating
      for (int i = 0; i < 27; i++) begin
         step(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0,
              (i % 9) != 8, (i % 9) == 8, "contend");
         check_val("contend.starve_le", {31'd0, (dut.starve_cnt_r <= 8'd8)}, 32'd1);
      end
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "contend_end");

      // Alternating VGA / AUX / VGA reads
      step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "alt0");
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b1, "alt1");
      step(1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "alt2");
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "alt_end");

      // Reset mid-read with an aux write presented during reset
      step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "rst_mid0");
      step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0200, 16'hDEAD, 1'b0, 1'b0, "rst_mid1");
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "rst_mid2");
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0, 1'b0, 1'b1, "rst_chk_rd");
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "rst_chk_ret");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
